pwm_gen: RTL and testbench

PWM_GEN -- requirements
Module: pwm_gen

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_timebase.sv | 63 ++++++
 rtl/pwm_gen.sv | 111 +++++++++++
 tb/tb_pwm_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM generator: default sizes and the register map.
package pwm_pkg;

  localparam int N_CH_DEF  = 7;
  localparam int CNT_W_DEF = 8;

  // Register addresses; duty registers occupy ADDR_DUTY0 .. ADDR_DUTY0+N_CH-1.
  localparam logic [3:0] ADDR_DUTY0  = 4'd0;
  localparam logic [3:0] ADDR_PERIOD = 4'd8;
  localparam logic [3:0] ADDR_PRESC  = 4'd9;
  localparam logic [3:0] ADDR_CTRL   = 4'd10;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler + main period counter. Counting starts one edge after enable
// rises (run_q), so the first cnt = 0 cycle follows the enable write by one
// edge and the registered outputs follow it by one more.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] per_act,
  input  logic [CNT_W-1:0] presc_act,
  output logic [CNT_W-1:0] cnt,
  output logic             running,
  output logic             boundary,
  output logic             first
);

  logic             run_q, run_d;
  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  // Status decode from the current counter values.
  always_comb begin
    running  = en && run_q;
    tick     = running && (pre_cnt_q == presc_act);
    boundary = tick && (cnt_q == per_act);
    first    = running && (pre_cnt_q == '0) && (cnt_q == '0);
    cnt      = cnt_q;
  end

  // Next counter values: held at zero when idle, wrap at the boundary.
  always_comb begin
    run_d     = en;
    pre_cnt_d = pre_cnt_q;
    cnt_d     = cnt_q;
    if (!running) begin
      pre_cnt_d = '0;
      cnt_d     = '0;
    end else if (tick) begin
      pre_cnt_d = '0;
      cnt_d     = boundary ? '0 : cnt_q + CNT_W'(1);
    end else begin
      pre_cnt_d = pre_cnt_q + CNT_W'(1);
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q     <= 1'b0;
      pre_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      run_q     <= run_d;
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// Multi-channel PWM generator with shadowed duty/period/prescaler registers.
// Shadows are written by the bus; active copies load at the period boundary
// (or continuously while not running), so a period never sees a torn update.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [CNT_W-1:0] wr_data,
  output logic [N_CH-1:0]  pwm_dc,
  output logic             period_start
);

  logic [CNT_W-1:0] duty_sh_q  [N_CH];
  logic [CNT_W-1:0] duty_sh_d  [N_CH];
  logic [CNT_W-1:0] duty_act_q [N_CH];
  logic [CNT_W-1:0] duty_act_d [N_CH];
  logic [CNT_W-1:0] per_sh_q, per_sh_d, per_act_q, per_act_d;
  logic [CNT_W-1:0] presc_sh_q, presc_sh_d, presc_act_q, presc_act_d;
  logic             en_q, en_d;
  logic [N_CH-1:0]  pwm_q, pwm_d;
  logic             ps_q, ps_d;

  logic [CNT_W-1:0] cnt;
  logic             running, boundary, first, load;

  pwm_timebase #(.CNT_W(CNT_W)) u_timebase (
    .clk       (clk),
    .rst       (rst),
    .en        (en_q),
    .per_act   (per_act_q),
    .presc_act (presc_act_q),
    .cnt       (cnt),
    .running   (running),
    .boundary  (boundary),
    .first     (first)
  );

  // Bus write decode into shadows and ctrl; unmapped addresses fall through.
  always_comb begin
    duty_sh_d  = duty_sh_q;
    per_sh_d   = per_sh_q;
    presc_sh_d = presc_sh_q;
    en_d       = en_q;
    if (wr_en) begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_addr == ADDR_DUTY0 + 4'(i)) duty_sh_d[i] = wr_data;
      end
      if (wr_addr == ADDR_PERIOD) per_sh_d   = wr_data;
      if (wr_addr == ADDR_PRESC)  presc_sh_d = wr_data;
      if (wr_addr == ADDR_CTRL)   en_d       = wr_data[0];
    end
  end

  // Active registers take the pre-write shadow at a boundary or when idle.
  always_comb begin
    load        = !running || boundary;
    duty_act_d  = duty_act_q;
    per_act_d   = per_act_q;
    presc_act_d = presc_act_q;
    if (load) begin
      duty_act_d  = duty_sh_q;
      per_act_d   = per_sh_q;
      presc_act_d = presc_sh_q;
    end
  end

  // Per-channel compare and period-start pulse, registered one edge after cnt.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      pwm_d[i] = running && (cnt < duty_act_q[i]);
    end
    ps_d = first;
  end

  // Register bank; reset wins over any coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
      per_sh_q    <= '1;
      per_act_q   <= '1;
      presc_sh_q  <= '0;
      presc_act_q <= '0;
      en_q        <= 1'b0;
      pwm_q       <= '0;
      ps_q        <= 1'b0;
    end else begin
      duty_sh_q   <= duty_sh_d;
      duty_act_q  <= duty_act_d;
      per_sh_q    <= per_sh_d;
      per_act_q   <= per_act_d;
      presc_sh_q  <= presc_sh_d;
      presc_act_q <= presc_act_d;
      en_q        <= en_d;
      pwm_q       <= pwm_d;
      ps_q        <= ps_d;
    end
  end

  assign pwm_dc       = pwm_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: every clock edge has an expected
// {period_start, pwm_dc} pushed to a queue and popped after the edge.
module tb_pwm_gen;
  import pwm_pkg::*;

  localparam int N_CH  = 7;
  localparam int CNT_W = 8;
  localparam int W     = N_CH + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [CNT_W-1:0] wr_data;
  logic [N_CH-1:0]  pwm_dc;
  logic             period_start;

  pwm_gen #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pwm_dc       (pwm_dc),
    .period_start (period_start)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int           chk_cnt  = 0;
  int           pass_cnt = 0;
  int           fail_cnt = 0;
  string        tag_s    = "reset";

  // Reference parameters for the expected waveform
  int p_m;
  int s_m;
  int duty_m[N_CH];

  // Expected outputs k cycles after the first period_start of a run.
  function automatic logic [W-1:0] model_at(input int k);
    int           pre;
    int           c;
    logic [W-1:0] v;
    pre = k % (s_m + 1);
    c   = (k / (s_m + 1)) % (p_m + 1);
    v   = '0;
    for (int i = 0; i < N_CH; i++) v[i] = (c < duty_m[i]);
    v[W-1] = (pre == 0) && (c == 0);
    return v;
  endfunction

  task automatic push_const(input logic [W-1:0] v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

  task automatic push_run(input int k0, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(model_at(k0 + i));
  endtask

  // One clock edge, then compare against the head of the queue.
  task automatic step();
    logic [W-1:0] obs_v;
    logic [W-1:0] exp_v;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      obs_v = {period_start, pwm_dc};
      chk_cnt++;
      assert (obs_v === exp_v) pass_cnt++;
      else begin
        fail_cnt++;
        $error("FAIL %s: observed %b expected %b", tag_s, obs_v, exp_v);
      end
    end
  endtask

  task automatic run(input int k0, input int n);
    push_run(k0, n);
    repeat (n) step();
  endtask

  // Write on the next edge; caller has already pushed that edge's expectation.
  task automatic wr(input logic [3:0] a, input logic [CNT_W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Write while outputs are expected idle.
  task automatic cfg(input logic [3:0] a, input logic [CNT_W-1:0] d);
    push_const('0, 1);
    wr(a, d);
  endtask

  // Enable write plus the one idle edge before the first period.
  task automatic start(input logic [CNT_W-1:0] d);
    cfg(ADDR_CTRL, d);
    push_const('0, 1);
    step();
  endtask

  task automatic set_model(input int p, input int s, input int d0, input int d1, input int d2);
    p_m = p;
    s_m = s;
    for (int i = 0; i < N_CH; i++) duty_m[i] = 0;
    duty_m[0] = d0;
    duty_m[1] = d1;
    duty_m[2] = d2;
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    // Reset state
    tag_s = "reset";
    push_const('0, 2);
    step();
    step();
    rst = 1'b0;

    // Basic: period 10, duty0 3, duty1 above period
    tag_s = "basic";
    cfg(ADDR_PRESC, 8'd0);
    cfg(ADDR_PERIOD, 8'd9);
    cfg(ADDR_DUTY0, 8'd3);
    cfg(ADDR_DUTY0 + 4'd1, 8'd10);
    start(8'hF1);
    set_model(9, 0, 3, 10, 0);
    run(0, 34);

    // Disable mid-period: this edge still shows k=34, next edge idle
    tag_s = "disable";
    push_run(34, 1);
    wr(ADDR_CTRL, 8'hFE);
    push_const('0, 3);
    repeat (3) step();

    // Prescaler: 12-cycle period, duty2 high 6 / low 6
    tag_s = "prescaler";
    cfg(ADDR_PRESC, 8'd2);
    cfg(ADDR_PERIOD, 8'd3);
    cfg(ADDR_DUTY0 + 4'd2, 8'd2);
    start(8'h01);
    set_model(3, 2, 3, 10, 2);
    run(0, 30);
    push_run(30, 1);
    wr(ADDR_CTRL, 8'h00);
    push_const('0, 1);
    step();

    // Shadow timing: mid-period write and a write on the boundary edge
    tag_s = "shadow";
    cfg(ADDR_PRESC, 8'd0);
    cfg(ADDR_PERIOD, 8'd9);
    cfg(ADDR_DUTY0 + 4'd1, 8'd0);
    cfg(ADDR_DUTY0 + 4'd2, 8'd0);
    start(8'h01);
    set_model(9, 0, 3, 0, 0);
    run(0, 5);
    push_run(5, 1);
    wr(ADDR_DUTY0, 8'd7);
    run(6, 4);
    duty_m[0] = 7;
    run(10, 9);
    push_run(19, 1);
    wr(ADDR_DUTY0, 8'd2);
    run(20, 10);
    duty_m[0] = 2;
    run(30, 10);
    push_run(40, 1);
    wr(ADDR_CTRL, 8'h00);
    push_const('0, 1);
    step();

    // Edge duties with the full-range period
    tag_s = "edge_duty";
    cfg(ADDR_PERIOD, 8'd255);
    cfg(ADDR_DUTY0, 8'd0);
    cfg(ADDR_DUTY0 + 4'd1, 8'd255);
    cfg(ADDR_DUTY0 + 4'd2, 8'd255);
    start(8'h01);
    set_model(255, 0, 0, 255, 255);
    run(0, 520);

    // Reset mid-period with a coincident write: write is lost
    tag_s = "reset_mid";
    push_const('0, 1);
    rst = 1'b1;
    wr(ADDR_DUTY0, 8'd5);
    rst = 1'b0;
    push_const('0, 3);
    repeat (3) step();

    // Unmapped writes must have no effect
    tag_s = "unmapped";
    cfg(4'd7, 8'hFF);
    cfg(4'd11, 8'h01);
    cfg(4'd15, 8'h01);
    push_const('0, 3);
    repeat (3) step();

    // Reset values in action: period 255, all duties 0
    tag_s = "reset_vals";
    start(8'h01);
    set_model(255, 0, 0, 0, 0);
    run(0, 12);
    push_run(12, 1);
    wr(ADDR_CTRL, 8'h00);
    push_const('0, 1);
    step();

    // Period 0: constant outputs, period_start every cycle
    tag_s = "period0";
    cfg(ADDR_PERIOD, 8'd0);
    cfg(ADDR_DUTY0, 8'd1);
    cfg(ADDR_DUTY0 + 4'd1, 8'd0);
    start(8'h01);
    set_model(0, 0, 1, 0, 0);
    run(0, 20);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
